// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch front end: machine word, HALT encoding,
// prefetch queue entry layout and prefetch queue state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Encoding of the HALT instruction; fetching stops once it is captured.
    localparam word_t HALT_INSTR = 32'hFFFF_FFFF;

    // One prefetch queue slot: the PC a word was fetched from and the word.
    typedef struct packed {
        word_t pc;
        word_t instr;
    } fq_entry_t;

    typedef enum logic {
        FQ_FETCH  = 1'b0,
        FQ_HALTED = 1'b1
    } fq_state_t;

    // Sequential successor of a PC; wraps modulo 2^32.
    function automatic word_t next_pc(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between the fetch unit and decode. Owns the
// imem read request, captures {pc, instr} pairs into a circular buffer and
// presents the oldest one to decode over a valid/ready handshake. Stops
// requesting after a HALT word is captured; flush drops everything queued.
module fetch_queue
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [31:0]             imemaddr,
    input  logic                    ihit,
    input  logic [31:0]             imemload,
    output logic                    iREN,
    output logic                    fetch_adv,
    input  logic                    flush,
    input  logic                    deq_ready,
    output logic                    out_valid,
    output logic [31:0]             out_instr,
    output logic [31:0]             out_pc,
    output logic [31:0]             out_npc,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    fq_state_t         state;
    fq_state_t         state_next;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    fq_entry_t         mem [DEPTH];
    fq_entry_t         head_entry;

    logic              is_full;
    logic              is_empty;
    logic              enq;
    logic              deq;

    assign is_full  = (count == FULL_COUNT);
    assign is_empty = (count == '0);

    // Request decode and next-state logic for the FETCH/HALTED machine.
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned; that is what keeps combinational blocks latch-free.
    always_comb begin
        state_next = state;
        iREN       = 1'b0;
        fetch_adv  = 1'b0;

        if (state == FQ_FETCH) begin
            iREN = !is_full;
        end

        // Reset forces the request off combinationally, ahead of the edge.
        if (RST) begin
            iREN = 1'b0;
        end

        // A word is captured only when requested, returned and not squashed.
        fetch_adv = iREN & ihit & ~flush;

        if (fetch_adv && (imemload == HALT_INSTR)) begin
            state_next = FQ_HALTED;
        end

        // Redirect beats the halt transition and reopens fetching.
        if (flush) begin
            state_next = FQ_FETCH;
        end
    end

    assign enq = fetch_adv;
    assign deq = out_valid & deq_ready & ~flush;

    // State register for the fetch/halt machine.
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers sample their inputs from the same pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FQ_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Head/tail pointers and occupancy; flush empties the queue in one cycle.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PTR_ONE;
            end
            if (deq) begin
                head <= head + PTR_ONE;
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; written at the tail on every capture.
    // NOTE: this array is deliberately reset so the head outputs read zero
    // during and straight after reset; flush leaves it alone because
    // out_valid already masks stale slots.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (enq) begin
            mem[tail] <= '{pc: imemaddr, instr: imemload};
        end
    end

    // Head outputs come straight from storage, so nothing from ihit or
    // imemload reaches them within the same cycle.
    assign head_entry = mem[head];
    assign out_valid  = !is_empty;
    assign out_instr  = head_entry.instr;
    assign out_pc     = head_entry.pc;
    assign out_npc    = next_pc(head_entry.pc);
    assign halted     = (state == FQ_HALTED);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a table of directed vectors with
// explicit expectations, hand-written corner sequences, and a queue-based
// reference model that every cycle is compared against.
module tb_fetch_queue;
    import cpu_types_pkg::*;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic        fetch_adv;
    logic        flush;
    logic        deq_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_npc;
    logic [2:0]  count;
    logic        halted;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .imemaddr  (imemaddr),
        .ihit      (ihit),
        .imemload  (imemload),
        .iREN      (iREN),
        .fetch_adv (fetch_adv),
        .flush     (flush),
        .deq_ready (deq_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_npc   (out_npc),
        .count     (count),
        .halted    (halted)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        ihit;
        logic [31:0] addr;
        logic [31:0] word;
        logic        dr;
        logic        fl;
        logic        exp_iren;
        logic        exp_adv;
        logic        exp_valid;
        logic [2:0]  exp_count;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: queued entries in FIFO order plus the halt flag.
    fq_entry_t sb[$];
    bit        m_halted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic ih, input logic [31:0] a,
                                input logic [31:0] w, input logic dr, input logic fl,
                                input logic e_iren, input logic e_adv, input logic e_valid,
                                input logic [2:0] e_count, input logic [31:0] e_instr,
                                input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.ihit = ih; v.addr = a; v.word = w; v.dr = dr; v.fl = fl;
        v.exp_iren = e_iren; v.exp_adv = e_adv; v.exp_valid = e_valid;
        v.exp_count = e_count; v.exp_instr = e_instr; v.exp_pc = e_pc;
        return v;
    endfunction

    // Drive one cycle of inputs, compare against the model (and the vector's
    // own expectations when chk is set), then advance the model past the edge.
    task automatic apply(input vec_t v, input bit chk);
        logic exp_iren, exp_adv, exp_valid, exp_deq;
        RST = v.rst; ihit = v.ihit; imemaddr = v.addr; imemload = v.word;
        deq_ready = v.dr; flush = v.fl;
        @(negedge CLK);
        exp_iren  = !v.rst && !m_halted && (sb.size() < DEPTH);
        exp_adv   = exp_iren && v.ihit && !v.fl;
        exp_valid = (sb.size() != 0);
        check("iREN",      32'(iREN),      32'(exp_iren));
        check("fetch_adv", 32'(fetch_adv), 32'(exp_adv));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("count",     32'(count),     32'(sb.size()));
        check("halted",    32'(halted),    32'(m_halted));
        if (exp_valid) begin
            check("out_instr", out_instr, sb[0].instr);
            check("out_pc",    out_pc,    sb[0].pc);
            check("out_npc",   out_npc,   sb[0].pc + 32'd4);
        end
        if (chk) begin
            check("vec_iren",  32'(iREN),      32'(v.exp_iren));
            check("vec_adv",   32'(fetch_adv), 32'(v.exp_adv));
            check("vec_valid", 32'(out_valid), 32'(v.exp_valid));
            check("vec_count", 32'(count),     32'(v.exp_count));
            if (v.exp_valid) begin
                check("vec_instr", out_instr, v.exp_instr);
                check("vec_pc",    out_pc,    v.exp_pc);
            end
        end
        exp_deq = exp_valid && v.dr && !v.fl;
        @(posedge CLK);
        #1;
        if (v.rst || v.fl) begin
            sb.delete();
            m_halted = 1'b0;
        end else begin
            if (exp_deq) void'(sb.pop_front());
            if (exp_adv) begin
                sb.push_back('{pc: v.addr, instr: v.word});
                if (v.word == HALT_INSTR) m_halted = 1'b1;
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic ih, input logic [31:0] a,
                       input logic [31:0] w, input logic dr, input logic fl);
        apply(mk(rst, ih, a, w, dr, fl, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0), 1'b0);
    endtask

    localparam logic [31:0] IA = 32'hA000_0001, IB = 32'hB000_0002, IC = 32'hC000_0003;
    localparam logic [31:0] D0 = 32'hD000_0010, D1 = 32'hD000_0011;
    localparam logic [31:0] D2 = 32'hD000_0012, D3 = 32'hD000_0013, IE = 32'hE000_0020;

    vec_t vecs[$];

    initial begin
        // Steady fetch A,B,C with decode always ready.
        vecs.push_back(mk(0,1,32'h00,IA,1,0, 1,1,0,3'd0,32'd0,32'h00));
        vecs.push_back(mk(0,1,32'h04,IB,1,0, 1,1,1,3'd1,IA,   32'h00));
        vecs.push_back(mk(0,1,32'h08,IC,1,0, 1,1,1,3'd1,IB,   32'h04));
        vecs.push_back(mk(0,0,32'h00,32'd0,1,0, 1,0,1,3'd1,IC,32'h08));
        vecs.push_back(mk(0,0,32'h00,32'd0,1,0, 1,0,0,3'd0,32'd0,32'h00));
        // Fill to full with decode stalled; fifth offered word is refused.
        vecs.push_back(mk(0,1,32'h10,D0,0,0, 1,1,0,3'd0,32'd0,32'h00));
        vecs.push_back(mk(0,1,32'h14,D1,0,0, 1,1,1,3'd1,D0,32'h10));
        vecs.push_back(mk(0,1,32'h18,D2,0,0, 1,1,1,3'd2,D0,32'h10));
        vecs.push_back(mk(0,1,32'h1C,D3,0,0, 1,1,1,3'd3,D0,32'h10));
        vecs.push_back(mk(0,1,32'h20,IE,0,0, 0,0,1,3'd4,D0,32'h10));
        // Dequeue while full: no same-cycle refill, iREN returns next cycle.
        vecs.push_back(mk(0,1,32'h20,IE,1,0, 0,0,1,3'd4,D0,32'h10));
        vecs.push_back(mk(0,1,32'h20,IE,0,0, 1,1,1,3'd3,D1,32'h14));
        vecs.push_back(mk(0,0,32'h00,32'd0,1,0, 0,0,1,3'd4,D1,32'h14));
        // Flush colliding with a hit and a dequeue at count 3.
        vecs.push_back(mk(0,1,32'h30,32'h3333_3333,1,1, 1,0,1,3'd3,D2,32'h18));
        vecs.push_back(mk(0,0,32'h00,32'd0,0,0, 1,0,0,3'd0,32'd0,32'h00));

        // Initial reset; storage reads zero and the request is held off.
        RST = 1'b1; ihit = 1'b1; imemaddr = '0; imemload = '0;
        deq_ready = 1'b0; flush = 1'b0;
        m_halted = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_count",  32'(count),     32'd0);
        check("rst_valid",  32'(out_valid), 32'd0);
        check("rst_halted", 32'(halted),    32'd0);
        check("rst_iren",   32'(iREN),      32'd0);
        check("rst_adv",    32'(fetch_adv), 32'd0);
        check("rst_instr",  out_instr,      32'd0);
        check("rst_pc",     out_pc,         32'd0);

        foreach (vecs[i]) apply(vecs[i], 1'b1);

        // HALT capture: fetching stops, queue drains, flush reopens fetch.
        cyc(0, 1, 32'h1C, 32'h600D_0001, 0, 0);
        cyc(0, 1, 32'h20, HALT_INSTR,    0, 0);
        check("halt_flag", 32'(halted), 32'd1);
        cyc(0, 1, 32'h24, 32'h1234_5678, 0, 0);
        repeat (3) cyc(0, 1, 32'h24, 32'h1234_5678, 1, 0);
        check("halt_still", 32'(halted), 32'd1);
        cyc(0, 0, 32'h0, 32'h0, 0, 1);
        RST = 1'b0; ihit = 1'b0; flush = 1'b0;
        #1;
        check("flush_iren", 32'(iREN), 32'd1);

        // Pointer wrap: ten captures interleaved with dequeues.
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 32'h100 + 32'(i * 4), $urandom, (i % 3) != 0, 0);
        end
        repeat (6) cyc(0, 0, 32'h0, 32'h0, 1, 0);

        // Next-PC wrap at the top of the address space.
        cyc(0, 1, 32'hFFFF_FFFC, 32'h0BAD_F00D, 0, 0);
        check("npc_wrap", out_npc, 32'd0);
        cyc(0, 0, 32'h0, 32'h0, 1, 0);

        // Reset mid-stream while halted with two entries queued.
        cyc(0, 1, 32'h40, 32'h4444_0000, 0, 0);
        cyc(0, 1, 32'h44, HALT_INSTR,    0, 0);
        check("mid_count",  32'(count),  32'd2);
        check("mid_halted", 32'(halted), 32'd1);
        cyc(1, 1, 32'h48, 32'h5555_0000, 1, 0);
        check("post_rst_count",  32'(count),  32'd0);
        check("post_rst_halted", 32'(halted), 32'd0);
        check("post_rst_pc",     out_pc,      32'd0);
        cyc(0, 1, 32'h48, 32'h5555_0000, 0, 0);
        cyc(0, 1, 32'h4C, 32'h5555_0004, 1, 0);
        repeat (3) cyc(0, 0, 32'h0, 32'h0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
